mix_state_serializer: RTL and testbench

Downstream stage of the 8-word state-mixing core. Once per frame it captures the core's eight 32-bit state words in parallel and emits them one word per beat on a valid/ready stream. It also keeps a rolling rotate-XOR digest of each frame and a count of completed frames. It decouples the mixer's wide, bursty state from a narrow sink that may apply backpressure.

---
 rtl/mix_state_serializer_pkg.sv | 18 +
 rtl/mix_state_serializer_if.sv | 29 ++
 rtl/mix_digest_acc.sv | 49 ++++
 rtl/mix_state_serializer.sv | 90 +++++++++
 tb/tb_mix_state_serializer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mix_state_serializer_pkg.sv
// Shared constants, FSM state type and the digest rotate helper for the
// state serializer and its digest accumulator.
package mix_state_serializer_pkg;

  localparam int WIDTH  = 32;
  localparam int NWORDS = 8;
  localparam int IDXW   = $clog2(NWORDS);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [WIDTH-1:0] rotl5(input logic [WIDTH-1:0] x);
    return {x[WIDTH-6:0], x[WIDTH-1:WIDTH-5]};
  endfunction

endpackage

// File: rtl/mix_state_serializer_if.sv
// Frame input, word stream output and digest status of the serializer.
interface mix_state_serializer_if;
  import mix_state_serializer_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [NWORDS*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [IDXW-1:0]         out_idx;
  logic                    out_last;
  logic [WIDTH-1:0]        digest;
  logic                    digest_valid;
  logic [15:0]             frame_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last,
           digest, digest_valid, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last,
           digest, digest_valid, frame_cnt
  );

endinterface

// File: rtl/mix_digest_acc.sv
// Rolling rotate-XOR digest over the words of a frame, plus the completed
// frame counter. A first strobe restarts the running value.
module mix_digest_acc
  import mix_state_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_first,
  input  logic             i_beat,
  input  logic             i_last,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_digest,
  output logic             o_digest_valid,
  output logic [15:0]      o_frame_cnt
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_digest;
  logic             r_digest_valid;
  logic [15:0]      r_frame_cnt;
  logic [WIDTH-1:0] w_mix;

  assign w_mix = rotl5(r_acc) ^ i_data;

  // A reload on the last beat clears the running value after it was folded
  // into the published digest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc          <= '0;
      r_digest       <= '0;
      r_digest_valid <= 1'b0;
      r_frame_cnt    <= '0;
    end else begin
      r_digest_valid <= 1'b0;
      if (i_beat) r_acc <= w_mix;
      if (i_first) r_acc <= '0;
      if (i_beat && i_last) begin
        r_digest       <= w_mix;
        r_digest_valid <= 1'b1;
        r_frame_cnt    <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign o_digest       = r_digest;
  assign o_digest_valid = r_digest_valid;
  assign o_frame_cnt    = r_frame_cnt;

endmodule

// File: rtl/mix_state_serializer.sv
// Captures an 8-word state frame in parallel and streams it out one word per
// beat; a new frame can be taken on the last beat so frames run back to back.
module mix_state_serializer
  import mix_state_serializer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  mix_state_serializer_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_armed;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_buf [NWORDS];
  logic             w_last;
  logic             w_beat;
  logic             w_in_hs;

  assign w_last  = (r_idx == IDXW'(NWORDS - 1));
  assign w_beat  = (r_state == SHIFT) && bus.out_ready;
  assign w_in_hs = bus.in_valid && bus.in_ready;

  // r_armed keeps in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_armed <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_in_hs) w_state_next = SHIFT;
      SHIFT:   if (w_beat && w_last && !w_in_hs) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    case (r_state)
      IDLE: bus.in_ready = r_armed;
      SHIFT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_buf[r_idx];
        bus.out_idx   = r_idx;
        bus.out_last  = w_last;
        bus.in_ready  = bus.out_ready && w_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_idx <= '0;
    else if (w_in_hs) r_idx <= '0;
    else if (w_beat)  r_idx <= r_idx + IDXW'(1);
  end

  // Buffer words are only written on a handshake, so no reset is needed.
  generate
    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (w_in_hs) r_buf[gi] <= bus.in_data[gi*WIDTH +: WIDTH];
      end
    end
  endgenerate

  mix_digest_acc u_acc (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_first        (w_in_hs),
    .i_beat         (w_beat),
    .i_last         (w_last),
    .i_data         (bus.out_data),
    .o_digest       (bus.digest),
    .o_digest_valid (bus.digest_valid),
    .o_frame_cnt    (bus.frame_cnt)
  );

endmodule

// File: tb/tb_mix_state_serializer.sv
// Directed and random frames against a queue-based model of the word stream,
// digest and frame counter.
module tb_mix_state_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mix_state_serializer_if bus ();

  mix_state_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  idx;
    logic [31:0] dig;
  } beat_t;

  beat_t       q[$];
  logic [31:0] m_digest = '0;
  logic        m_dv = 1'b0;
  logic [15:0] m_cnt = '0;
  logic        m_armed = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  int          dut_beats = 0;

  function automatic logic [31:0] frame_digest(input logic [255:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[26:0], r[31:27]} ^ d[i*32 +: 32];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, compare 1ns later, then advance the
  // model to what the next rising edge should do.
  task automatic step(input logic iv, input logic [255:0] d, input logic ordy);
    logic  ev, exp_ir, bt, hs;
    beat_t h;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    ev     = (q.size() != 0);
    h      = ev ? q[0] : '0;
    exp_ir = (!ev && m_armed) || (q.size() == 1 && ordy);
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("out_data", bus.out_data, h.data);
    chk("out_idx", 32'(bus.out_idx), 32'(h.idx));
    chk("out_last", 32'(bus.out_last), 32'(ev && h.idx == 3'd7));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
    chk("digest", bus.digest, m_digest);
    chk("digest_valid", 32'(bus.digest_valid), 32'(m_dv));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
    if (bus.out_valid && ordy) dut_beats++;
    bt   = ev && ordy;
    hs   = iv && exp_ir;
    m_dv = 1'b0;
    if (bt) begin
      void'(q.pop_front());
      if (h.idx == 3'd7) begin
        m_digest = h.dig;
        m_dv     = 1'b1;
        m_cnt    = m_cnt + 16'd1;
        $display("frame done digest=%08h cnt=%0d", h.dig, m_cnt);
      end
    end
    if (hs) begin
      hs_cnt++;
      for (int i = 0; i < 8; i++) q.push_back('{d[i*32 +: 32], 3'(i), frame_digest(d)});
      $display("frame accepted w0=%08h w7=%08h", d[31:0], d[255:224]);
    end
    m_armed = 1'b1;
  endtask

  function automatic logic [255:0] rand_frame();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"}, bus.out_data, 32'd0);
    chk({tag, "_out_idx"}, 32'(bus.out_idx), 32'd0);
    chk({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_digest"}, bus.digest, 32'd0);
    chk({tag, "_digest_valid"}, 32'(bus.digest_valid), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_digest = '0;
    m_dv     = 1'b0;
    m_cnt    = '0;
    m_armed  = 1'b0;
  endtask

  initial begin
    logic [255:0] ramp, ones, d1, d2;
    int b0, h0, guard;
    logic [15:0] c0;
    for (int i = 0; i < 8; i++) ramp[i*32 +: 32] = 32'(i);
    ones = '1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset behaviour and first clock after release
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_release", 32'(bus.in_ready), 32'd0);
    m_armed = 1'b1;
    step(0, '0, 1);

    // Ramp frame, no backpressure
    step(1, ramp, 1);
    repeat (10) step(0, rand_frame(), 1);
    chk("ramp_digest", bus.digest, 32'd1144132807);
    chk("ramp_cnt", 32'(bus.frame_cnt), 32'd1);

    // All-ones frame cancels to zero
    step(1, ones, 1);
    repeat (10) step(0, '0, 1);
    chk("ones_digest", bus.digest, 32'd0);

    // Backpressure pattern 1,0,0,1
    step(1, ramp, 1);
    b0 = dut_beats;
    for (int k = 0; k < 40; k++) step(0, rand_frame(), (k % 4 == 0) || (k % 4 == 3));
    chk("bp_beats", 32'(dut_beats - b0), 32'd8);
    chk("bp_digest", bus.digest, 32'd1144132807);

    // Back-to-back frames with in_valid held high
    d1 = rand_frame();
    d2 = rand_frame();
    h0 = hs_cnt;
    c0 = bus.frame_cnt;
    guard = 0;
    while (hs_cnt < h0 + 2 && guard < 50) begin
      step(1, (hs_cnt == h0) ? d1 : d2, 1);
      guard++;
    end
    chk("b2b_handshakes", 32'(hs_cnt - h0), 32'd2);
    repeat (10) step(0, '0, 1);
    chk("b2b_cnt", 32'(bus.frame_cnt), 32'(c0 + 16'd2));

    // Random traffic
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 1)), rand_frame(), 1'($urandom_range(0, 3) != 0));
    repeat (30) step(0, '0, 1);

    // Reset in the middle of a frame
    step(1, rand_frame(), 1);
    repeat (3) step(0, '0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_rerelease", 32'(bus.in_ready), 32'd0);
    m_armed = 1'b1;
    repeat (3) step(0, '0, 1);

    // Counter wrap from 0xFFFF
    @(negedge clk);
    force dut.u_acc.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.u_acc.r_frame_cnt;
    m_cnt = 16'hFFFF;
    step(0, '0, 1);
    step(1, rand_frame(), 1);
    repeat (10) step(0, '0, 1);
    chk("cnt_wrap", 32'(bus.frame_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
